// File: rtl/arb_pkg.sv
// arb_pkg: state encoding and default sizing shared by arbiter clients and benches.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

  localparam int unsigned ARB_LEN_W   = 4;
  localparam int unsigned ARB_GAP_CYC = 1;
  localparam int unsigned ARB_TMO_W   = 8;

  // Minimum counter width able to hold n-1 (never narrower than one bit).
  function automatic int unsigned arb_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_client_cnt.sv
// arb_client_cnt: loadable down-counter with zero flag; load wins over decrement,
// and the count holds at zero instead of wrapping.
module arb_client_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/arb_client.sv
// arb_client: turns burst commands into an arbiter req/gnt handshake, holding req for
// cmd_len+1 granted beats then idling GAP_CYC cycles. ARB_CLIENT_TIMEOUT_EN adds tmo.
module arb_client
  import arb_pkg::*;
#(
  parameter int unsigned LEN_W   = ARB_LEN_W,
  parameter int unsigned GAP_CYC = ARB_GAP_CYC
`ifdef ARB_CLIENT_TIMEOUT_EN
  ,
  parameter int unsigned TMO_W   = ARB_TMO_W
`endif
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             req,
  input  logic             gnt,
  output logic             beat,
  output logic             done,
  output logic             busy
`ifdef ARB_CLIENT_TIMEOUT_EN
  ,
  output logic             tmo
`endif
);

  localparam int unsigned GAP_W = arb_cnt_w(GAP_CYC);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

  arb_state_t state;
  logic       accept;
  logic       rem_zero;
  logic       gap_zero;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign beat      = (state == XFER) && gnt;
  assign done      = beat && rem_zero;

  arb_client_cnt #(.W(LEN_W)) u_rem (
    .clk      (clk),
    .nreset   (nreset),
    .load     (accept),
    .load_val (cmd_len),
    .dec      (beat),
    .zero     (rem_zero)
  );

  // Reloaded on the final beat so the GAP phase always starts from a full count.
  arb_client_cnt #(.W(GAP_W)) u_gap (
    .clk      (clk),
    .nreset   (nreset),
    .load     (done),
    .load_val (GAP_LOAD),
    .dec      (state == GAP),
    .zero     (gap_zero)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
      req   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= REQ;
            req   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        REQ: begin
          if (gnt) begin
            state <= XFER;
          end
        end
        XFER: begin
          if (done) begin
            state <= GAP;
            req   <= 1'b0;
          end
        end
        GAP: begin
          if (gap_zero) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_CLIENT_TIMEOUT_EN
  logic [TMO_W-1:0] wcnt;
  logic             wait_inc;

  assign wait_inc = ((state == REQ) || (state == XFER)) && !gnt;

  // tmo fires only on the step into all-ones; the saturated count holds it low afterwards.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wcnt <= '0;
      tmo  <= 1'b0;
    end else begin
      tmo <= 1'b0;
      if (accept || beat) begin
        wcnt <= '0;
      end else if (wait_inc && (wcnt != '1)) begin
        wcnt <= wcnt + TMO_W'(1);
        if (wcnt == ~TMO_W'(1)) begin
          tmo <= 1'b1;
        end
      end
    end
  end
`endif

endmodule
